// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage RAW stall, sticky halt and stall counter for a no-forwarding pipeline
module id_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rs_id,
  input  logic [2:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic [2:0]  Write_register_id,
  input  logic        RegWrite_id,
  input  logic        halt_id,
  input  logic        flush,
  output logic        stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        halted,
  output logic [15:0] stall_cnt
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nxt;
  logic ex_v, mem_v;
  logic [2:0] ex_reg, mem_reg;
  logic rs_hit, rt_hit, raw;
  // WB is covered by the register-file bypass, so only EX and MEM are tracked
  assign rs_hit = (ex_v && ex_reg == rs_id) || (mem_v && mem_reg == rs_id);
  assign rt_hit = (ex_v && ex_reg == rt_id) || (mem_v && mem_reg == rt_id);
  assign raw    = (use_rs_id && rs_hit) || (use_rt_id && rt_hit);
  // state register; HALT is only left through reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_nxt;
  // a stalled or flushed HALT does not take effect; it retries next cycle
  always_comb
    state_nxt = (state == RUN && halt_id && !stall && !flush) ? HALT : state;
  // outputs are held at their inactive values while reset is asserted
  always_comb begin
    stall       = !rst ? 1'b0 : (state == HALT) ? 1'b1 : raw && !flush;
    pc_write    = rst && !stall;
    if_id_write = rst && !stall;
    halted      = rst && state == HALT;
  end
  // scoreboard shift: ID -> EX -> MEM; bubbles and killed instructions enter invalid
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex_v    <= 1'b0;
      ex_reg  <= 3'd0;
      mem_v   <= 1'b0;
      mem_reg <= 3'd0;
    end else begin
      mem_v   <= ex_v;
      mem_reg <= ex_reg;
      ex_v    <= RegWrite_id && !stall && !flush && state == RUN;
      ex_reg  <= Write_register_id;
    end
  // saturating count of RAW stall cycles (halt cycles are not counted)
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= 16'd0;
    else if (state == RUN && stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
endmodule
